// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel/line counters, sync and blanking levels, tick and start strobes.
interface vga_timing_if;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        pix_tick;
    logic        line_start;
    logic        frame_start;

    modport master (output hc, vc, hsync, vsync, blank, pix_tick, line_start, frame_start);
    modport slave  (input  hc, vc, hsync, vsync, blank, pix_tick, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: every output is a flop, derived from next-state counters so all
// fields describe the same pixel; free-running, no backpressure.
module vga_timing_gen #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 1
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV must be within 1..16");
    end

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]  dcnt;
    logic [3:0]  dcnt_nxt;
    logic        tick_nxt;
    logic [10:0] hc_nxt;
    logic [10:0] vc_nxt;
    // Marks that the presented hc==0 was reached by a wrap, not by reset.
    logic        wrapped;
    logic        wrap_nxt;

    always_comb begin
        dcnt_nxt = (dcnt == DIV_LAST) ? 4'd0 : dcnt + 4'd1;
        tick_nxt = (dcnt_nxt == DIV_LAST);
        hc_nxt   = vga.hc;
        vc_nxt   = vga.vc;
        wrap_nxt = wrapped;
        if (vga.pix_tick) begin
            wrap_nxt = (vga.hc == H_LAST);
            if (vga.hc == H_LAST) begin
                hc_nxt = 11'd0;
                vc_nxt = (vga.vc == V_LAST) ? 11'd0 : vga.vc + 11'd1;
            end else begin
                hc_nxt = vga.hc + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt            <= 4'd0;
            wrapped         <= 1'b0;
            vga.hc          <= 11'd0;
            vga.vc          <= 11'd0;
            vga.pix_tick    <= 1'b0;
            vga.hsync       <= ~HSYNC_POL;
            vga.vsync       <= ~VSYNC_POL;
            vga.blank       <= 1'b0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            dcnt            <= dcnt_nxt;
            wrapped         <= wrap_nxt;
            vga.hc          <= hc_nxt;
            vga.vc          <= vc_nxt;
            vga.pix_tick    <= tick_nxt;
            vga.hsync       <= (hc_nxt >= HS_FIRST && hc_nxt <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
            vga.vsync       <= (vc_nxt >= VS_FIRST && vc_nxt <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
            vga.blank       <= (hc_nxt >= H_VIS) || (vc_nxt >= V_VIS);
            vga.line_start  <= wrap_nxt & tick_nxt;
            vga.frame_start <= wrap_nxt & tick_nxt & (vc_nxt == 11'd0);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: four generators (defaults, defaults /4, small raster, small raster with inverted syncs)
// checked every cycle against an arithmetic raster model plus hand-computed anchor points.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hsync;
        logic        vsync;
        logic        blank;
        logic        pix_tick;
        logic        line_start;
        logic        frame_start;
    } obs_t;

    localparam int NI = 4;
    localparam int HV [NI] = '{1024, 1024, 20, 20};
    localparam int HF [NI] = '{24, 24, 2, 2};
    localparam int HS [NI] = '{136, 136, 4, 4};
    localparam int HB [NI] = '{160, 160, 4, 4};
    localparam int VV [NI] = '{768, 768, 10, 10};
    localparam int VF [NI] = '{3, 3, 2, 2};
    localparam int VS [NI] = '{6, 6, 3, 3};
    localparam int VB [NI] = '{29, 29, 3, 3};
    localparam int DV [NI] = '{1, 4, 1, 1};
    localparam bit HP [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam bit VP [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_if if0 ();
    vga_timing_if if1 ();
    vga_timing_if if2 ();
    vga_timing_if if3 ();

    vga_timing_gen u0 (.clk(clk), .rst(rst), .vga(if0));
    vga_timing_gen #(.CLK_DIV(4)) u1 (.clk(clk), .rst(rst), .vga(if1));
    vga_timing_gen #(.H_VISIBLE(20), .H_FP(2), .H_SYNC(4), .H_BP(4),
                     .V_VISIBLE(10), .V_FP(2), .V_SYNC(3), .V_BP(3)) u2 (.clk(clk), .rst(rst), .vga(if2));
    vga_timing_gen #(.H_VISIBLE(20), .H_FP(2), .H_SYNC(4), .H_BP(4),
                     .V_VISIBLE(10), .V_FP(2), .V_SYNC(3), .V_BP(3),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u3 (.clk(clk), .rst(rst), .vga(if3));

    obs_t obs [NI];
    assign obs[0] = {if0.hc, if0.vc, if0.hsync, if0.vsync, if0.blank, if0.pix_tick, if0.line_start, if0.frame_start};
    assign obs[1] = {if1.hc, if1.vc, if1.hsync, if1.vsync, if1.blank, if1.pix_tick, if1.line_start, if1.frame_start};
    assign obs[2] = {if2.hc, if2.vc, if2.hsync, if2.vsync, if2.blank, if2.pix_tick, if2.line_start, if2.frame_start};
    assign obs[3] = {if3.hc, if3.vc, if3.hsync, if3.vsync, if3.blank, if3.pix_tick, if3.line_start, if3.frame_start};

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    mvalid = 1'b0;
    longint kk = 0;   // clk cycles since the last edge that sampled rst=1
    int    ls2, fs2, fs2_first, vs2, bl2, vs3, hs3, hs0, hs1, tk1;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Position follows from how many pixel ticks have completed since reset.
    function automatic obs_t expect_at(input int i, input longint k);
        obs_t   e;
        longint n, pos;
        int     ht, vt, h, v;
        bit     tick;
        ht   = HV[i] + HF[i] + HS[i] + HB[i];
        vt   = VV[i] + VF[i] + VS[i] + VB[i];
        tick = (k > 0) && (((k + 1) % DV[i]) == 0);
        if (k == 0)          n = 0;
        else if (DV[i] == 1) n = k - 1;
        else                 n = k / DV[i];
        pos = n % (ht * vt);
        h   = int'(pos % ht);
        v   = int'(pos / ht);
        e.hc          = 11'(h);
        e.vc          = 11'(v);
        e.hsync       = (h >= HV[i] + HF[i] && h < HV[i] + HF[i] + HS[i]) ? HP[i] : !HP[i];
        e.vsync       = (v >= VV[i] + VF[i] && v < VV[i] + VF[i] + VS[i]) ? VP[i] : !VP[i];
        e.blank       = (h >= HV[i]) || (v >= VV[i]);
        e.pix_tick    = tick;
        e.line_start  = tick && (h == 0) && (n > 0);
        e.frame_start = e.line_start && (v == 0);
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mvalid = 1'b1;
            kk = 0;
            ls2 = 0; fs2 = 0; fs2_first = 0; vs2 = 0; bl2 = 0;
            vs3 = 0; hs3 = 0; hs0 = 0; hs1 = 0; tk1 = 0;
        end else if (mvalid) begin
            kk++;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < NI; i++) begin
                obs_t e;
                e = expect_at(i, kk);
                n_cmp++;
                if (obs[i] !== e) begin
                    n_bad++;
                    $display("FAIL model[%0d] cycle %0d: got hc=%0d vc=%0d hs=%b vs=%b bl=%b tk=%b ls=%b fs=%b, expected hc=%0d vc=%0d hs=%b vs=%b bl=%b tk=%b ls=%b fs=%b",
                             i, kk, obs[i].hc, obs[i].vc, obs[i].hsync, obs[i].vsync, obs[i].blank,
                             obs[i].pix_tick, obs[i].line_start, obs[i].frame_start,
                             e.hc, e.vc, e.hsync, e.vsync, e.blank, e.pix_tick, e.line_start, e.frame_start);
                end
            end
            if (kk >= 1 && kk <= 541) begin
                ls2 += int'(obs[2].line_start);
                fs2 += int'(obs[2].frame_start);
                if (obs[2].frame_start && fs2_first == 0) fs2_first = int'(kk);
            end
            if (kk >= 1 && kk <= 540) begin
                vs2 += int'(!obs[2].vsync);
                bl2 += int'(obs[2].blank);
                vs3 += int'(obs[3].vsync);
            end
            if (kk >= 1 && kk <= 30)   hs3 += int'(obs[3].hsync);
            if (kk >= 1 && kk <= 1344) hs0 += int'(!obs[0].hsync);
            if (kk >= 1 && kk <= 5376) begin
                hs1 += int'(!obs[1].hsync);
                tk1 += int'(obs[1].pix_tick);
            end
            // Hand-computed anchors
            if (kk == 1024) chk("blank_hc1023", obs[0].blank, 0);
            if (kk == 1025) begin
                chk("hc_at_1025", obs[0].hc, 1024);
                chk("blank_hc1024", obs[0].blank, 1);
            end
            if (kk == 1048) chk("hsync_hc1047", obs[0].hsync, 1);
            if (kk == 1049) chk("hsync_hc1048", obs[0].hsync, 0);
            if (kk == 1184) chk("hsync_hc1183", obs[0].hsync, 0);
            if (kk == 1185) chk("hsync_hc1184", obs[0].hsync, 1);
            if (kk == 1345) begin
                chk("wrap_hc", obs[0].hc, 0);
                chk("wrap_vc", obs[0].vc, 1);
                chk("wrap_line_start", obs[0].line_start, 1);
            end
            if (kk == 7) begin
                chk("div4_hc_k7", obs[1].hc, 1);
                chk("div4_tick_k7", obs[1].pix_tick, 1);
            end
            if (kk == 8) begin
                chk("div4_hc_k8", obs[1].hc, 2);
                chk("div4_tick_k8", obs[1].pix_tick, 0);
            end
            if (kk == 540) begin
                chk("small_last_hc", obs[2].hc, 29);
                chk("small_last_vc", obs[2].vc, 17);
            end
            if (kk == 541) chk("small_frame_start", obs[2].frame_start, 1);
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_hc", if0.hc, 0);
        chk("reset_tick", if0.pix_tick, 0);
        chk("reset_hsync_pol1", if3.hsync, 0);
        // Run into the second small frame, then reset at hc=15, vc=7.
        repeat (766) @(posedge clk);
        @(negedge clk);
        chk("pre_pulse_hc", if2.hc, 15);
        chk("pre_pulse_vc", if2.vc, 7);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_pulse_hc", if2.hc, 0);
        chk("post_pulse_vc", if2.vc, 0);
        chk("post_pulse_hsync", if2.hsync, 1);
        chk("post_pulse_tick", if2.pix_tick, 0);
        repeat (5400) @(posedge clk);
        @(negedge clk);
        chk("line_starts_per_frame", ls2, 18);
        chk("frame_starts_per_frame", fs2, 1);
        chk("first_frame_start_cycle", fs2_first, 541);
        chk("vsync_low_cycles", vs2, 90);
        chk("blank_cycles_per_frame", bl2, 340);
        chk("vsync_high_cycles_pol1", vs3, 90);
        chk("hsync_high_cycles_pol1", hs3, 4);
        chk("hsync_low_cycles", hs0, 136);
        chk("hsync_low_clks_div4", hs1, 544);
        chk("ticks_per_line_div4", tk1, 1344);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock and rst is sampled on the clk rising edge.
REQ-002 Parameters (name, default, meaning) SHALL be:
- H_VISIBLE, 1024, visible pixels per line.
- H_FP, 24, horizontal front porch.
- H_SYNC, 136, horizontal sync width.
- H_BP, 160, horizontal back porch.
- V_VISIBLE, 768, visible lines.
- V_FP, 3, vertical front porch.
- V_SYNC, 6, vertical sync width.
- V_BP, 29, vertical back porch.
- HSYNC_POL, 0, hsync active level.
- VSYNC_POL, 0, vsync active level.
- CLK_DIV, 1, clk cycles per pixel (1..16).
REQ-003 Ports (name direction width meaning) SHALL be:
- clk in 1 clock.
- rst in 1 sync reset.
- hc out 11 pixel column.
- vc out 11 line number.
- hsync out 1 horizontal sync.
- vsync out 1 vertical sync.
- blank out 1 high outside the visible area.
- pix_tick out 1 counters advance at the end of this cycle.
- line_start out 1 first tick of a line.
- frame_start out 1 first tick of a frame.
REQ-004 All outputs SHALL be driven directly from flops; there SHALL be no combinational input-to-output path.

Function
REQ-005 Derived totals SHALL be H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 1344) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 806); both SHALL be at most 2048 (elaboration check).
REQ-006 The divider dcnt SHALL count 0..CLK_DIV-1 and wrap; pix_tick SHALL be 1 exactly in cycles where dcnt==CLK_DIV-1. With CLK_DIV=1, pix_tick SHALL be constantly 1 outside reset.
REQ-007 On a clk edge closing a pix_tick cycle, hc SHALL increment; hc==H_TOTAL-1 SHALL wrap hc to 0 and increment vc.
REQ-008 vc==V_TOTAL-1 at an hc wrap SHALL wrap vc to 0; hc and vc SHALL never exceed H_TOTAL-1 and V_TOTAL-1.
REQ-009 Without pix_tick, hc and vc SHALL hold.
REQ-010 hsync, vsync and blank SHALL be computed from next-state counters so they align with the hc/vc presented in the same cycle.
REQ-011 hsync SHALL equal HSYNC_POL iff H_VISIBLE+H_FP <= hc <= H_VISIBLE+H_FP+H_SYNC-1 (default 1048..1183), else ~HSYNC_POL.
REQ-012 vsync SHALL equal VSYNC_POL iff V_VISIBLE+V_FP <= vc <= V_VISIBLE+V_FP+V_SYNC-1 (default 771..776), else ~VSYNC_POL.
REQ-013 blank SHALL be 1 iff hc >= H_VISIBLE or vc >= V_VISIBLE.
REQ-014 line_start SHALL be 1 in the pix_tick cycle where hc==0, but only when that hc==0 was reached by a wrap.
REQ-015 frame_start SHALL be 1 in the pix_tick cycle where hc==0 and vc==0, but only when reached by a wrap.
REQ-016 line_start and frame_start SHALL never assert in the pix_tick cycle immediately after reset release.
REQ-017 frame_start SHALL imply line_start.

Reset
REQ-018 While rst=1 and on the cycle after it, outputs SHALL be: hc=0, vc=0, dcnt=0, pix_tick=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, blank=0, line_start=0, frame_start=0.
REQ-019 rst asserted mid-line or mid-frame SHALL take priority over any pix_tick, and counting SHALL restart from (0,0) with dcnt=0 on release.

Verification
REQ-020 The bench SHALL cover these scenarios (stimulus -> required response), all on defaults unless stated:
- Reset, run 1344*806 ticks -> exactly one frame_start, 806 line_start, vc wraps 805->0 while hc wraps 1343->0.
- hc sweep -> hsync=0 for hc 1048..1183 only (136 cycles/line); blank rises at hc=1024.
- vc sweep -> vsync=0 for vc 771..776 only; blank=1 for all hc on vc 768..805.
- CLK_DIV=4 -> pix_tick every 4th clk; hc holds 3 clks between increments; hsync width 544 clks.
- rst pulsed at hc=500, vc=300 -> next cycle hc=0, vc=0, hsync=1, no frame_start until the following full frame.
- HSYNC_POL=1, VSYNC_POL=1 -> sync levels inverted, same positions and widths as the defaults.
